// File: rtl/lfsr_prbs_lock_check_if.sv
// Stream-side bundle of the PRBS lock checker.
// The master drives received words and the count clear; the slave returns the error flags, lock status and error count.
interface lfsr_prbs_lock_check_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]  data_in;
  logic                   data_in_valid;
  logic                   clear_count;
  logic [DATA_WIDTH-1:0]  error_out;
  logic                   error_valid;
  logic                   locked;
  logic [COUNT_WIDTH-1:0] error_count;

  modport master (
    output data_in, data_in_valid, clear_count,
    input  error_out, error_valid, locked, error_count
  );

  modport slave (
    input  data_in, data_in_valid, clear_count,
    output error_out, error_valid, locked, error_count
  );
endinterface

// File: rtl/lfsr_prbs_lock_check.sv
// Self-synchronising PRBS checker with SEARCH/LOCKED lock tracking.
// Defining LFSR_PRBS_LOCK_CHECK_ERR_COUNT_EN adds the saturating error counter.
module lfsr_prbs_lock_check #(
  parameter int                    LFSR_WIDTH   = 9,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 9'h021,
  parameter string                 LFSR_CONFIG  = "FIBONACCI",
  parameter int                    REVERSE      = 0,
  parameter int                    INVERT       = 0,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    LOCK_COUNT   = 4,
  parameter int                    UNLOCK_COUNT = 8,
  parameter int                    COUNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  lfsr_prbs_lock_check_if.slave bus
);
  localparam int RUN_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);

  // Bit k-1 of the mask selects the received bit k positions back; the x^W term is always tapped.
  function automatic logic [LFSR_WIDTH-1:0] tap_mask_f();
    logic [LFSR_WIDTH-1:0] m;
    m = '0;
    m[LFSR_WIDTH-1] = 1'b1;
    for (int k = 1; k < LFSR_WIDTH; k++) begin
      if (LFSR_POLY[k]) begin
        if (LFSR_CONFIG == "GALOIS") m[LFSR_WIDTH-1-k] = 1'b1;
        else                         m[k-1] = 1'b1;
      end
    end
    return m;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] TAP_MASK = tap_mask_f();

  typedef enum logic {SEARCH, LOCKED} lock_state_e;

  lock_state_e             fsm_q, fsm_d;
  logic [LFSR_WIDTH-1:0]   state_q, state_d;
  logic [RUN_W-1:0]        run_q, run_d;
  logic [DATA_WIDTH-1:0]   err_q, err_d;
  logic                    err_valid_q, err_valid_d;
  logic                    locked_q, locked_d;
  logic [DATA_WIDTH-1:0]   word_inv, word, err_now;
  logic [LFSR_WIDTH-1:0]   shift;

  // The MSB of each word is the earliest bit in time.
  always_comb begin
    word_inv = (INVERT != 0) ? ~bus.data_in : bus.data_in;
    word     = word_inv;
    if (REVERSE != 0) begin
      for (int i = 0; i < DATA_WIDTH; i++) word[i] = word_inv[DATA_WIDTH-1-i];
    end
    shift   = state_q;
    err_now = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      err_now[i] = word[i] ^ (^(shift & TAP_MASK));
      shift      = {shift[LFSR_WIDTH-2:0], word[i]};
    end
    state_d     = bus.data_in_valid ? shift : state_q;
    err_d       = bus.data_in_valid ? err_now : err_q;
    err_valid_d = bus.data_in_valid;
  end

  always_comb begin
    fsm_d = fsm_q;
    run_d = run_q;
    if (bus.data_in_valid) begin
      if (fsm_q == SEARCH) begin
        if (err_now == '0) begin
          if (run_q == RUN_W'(LOCK_COUNT - 1)) begin
            fsm_d = LOCKED;
            run_d = '0;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end else begin
          run_d = '0;
        end
      end else begin
        if (err_now != '0) begin
          if (run_q == RUN_W'(UNLOCK_COUNT - 1)) begin
            fsm_d = SEARCH;
            run_d = '0;
          end else begin
            run_d = run_q + RUN_W'(1);
          end
        end else begin
          run_d = '0;
        end
      end
    end
    locked_d = (fsm_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= '1;
      fsm_q       <= SEARCH;
      run_q       <= '0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fsm_q       <= fsm_d;
      run_q       <= run_d;
      err_q       <= err_d;
      err_valid_q <= err_valid_d;
      locked_q    <= locked_d;
    end
  end

  assign bus.error_out   = err_q;
  assign bus.error_valid = err_valid_q;
  assign bus.locked      = locked_q;

`ifdef LFSR_PRBS_LOCK_CHECK_ERR_COUNT_EN
  localparam int PC_W  = $clog2(DATA_WIDTH + 1);
  localparam int SUM_W = ((COUNT_WIDTH > PC_W) ? COUNT_WIDTH : PC_W) + 1;

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [SUM_W-1:0]       pop, sum;

  // Only words that arrive while already locked are counted; clear beats any increment.
  always_comb begin
    pop = '0;
    for (int i = 0; i < DATA_WIDTH; i++) pop = pop + SUM_W'(err_now[i]);
    sum     = SUM_W'(count_q) + pop;
    count_d = count_q;
    if (bus.clear_count) begin
      count_d = '0;
    end else if (bus.data_in_valid && fsm_q == LOCKED) begin
      count_d = (sum > SUM_W'({COUNT_WIDTH{1'b1}})) ? '1 : sum[COUNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign bus.error_count = count_q;
`else
  logic unused_clear_count;
  assign unused_clear_count = bus.clear_count;
  assign bus.error_count    = '0;
`endif
endmodule
